sevenseg_matrix_scanner: RTL



---
 rtl/sevenseg_matrix_scanner_if.sv | 21 ++
 rtl/sevenseg_matrix_scanner.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sevenseg_matrix_scanner_if.sv
// Load handshake bundle for the seven-segment matrix scanner.
// The master presents active-low segment data, the scanner accepts it.
interface sevenseg_matrix_scanner_if #(
  parameter int DIGITS = 1
);
  logic [8*DIGITS-1:0] seg_in;
  logic                load_valid;
  logic                load_ready;

  modport master (
    output seg_in,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  seg_in,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/sevenseg_matrix_scanner.sv
// Seven-segment to LED-matrix column scanner with tear-free loads and PWM.
// Optional macro SEVENSEG_DP_EN routes dp to row 7 of each digit's column 3.
module sevenseg_matrix_scanner #(
  parameter int DIGITS     = 1,
  parameter int PRESCALE_W = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sevenseg_matrix_scanner_if.slave load,
  input  logic [3:0]            bright,
  input  logic                  en,
  output logic [7:0]            io_out,
  output logic [4*DIGITS-1:0]   io_col,
  output logic                  frame_start
);
  localparam int NCOL = 4 * DIGITS;
  localparam int CW   = $clog2(NCOL);
  localparam logic [CW-1:0] LAST = CW'(NCOL - 1);

  logic [PRESCALE_W-1:0] presc;
  logic [CW-1:0]         col_idx;
  logic [8*DIGITS-1:0]   disp;
  logic [8*DIGITS-1:0]   pend;
  logic                  pend_full;
  logic                  wrap;
  logic                  boundary;
  logic                  accept;
  logic                  lit;
  logic [CW-1:0]         digit;
  logic [7:0]            seg;
  logic [7:0]            rows;
  logic [NCOL-1:0]       col_n;

  assign wrap     = &presc;
  assign boundary = wrap && (col_idx == LAST);

  assign load.load_ready = !pend_full;
  assign accept = load.load_valid && !pend_full;

  // Top four prescaler bits split the slot into 16 PWM steps.
  assign lit = en && (presc[PRESCALE_W-1 -: 4] <= bright);

  assign digit = col_idx >> 2;
  assign seg   = 8'(disp >> {digit, 3'b000});
  assign col_n = ~(NCOL'(1) << col_idx);

`ifndef SEVENSEG_DP_EN
  logic unused_dp;
  assign unused_dp = seg[7];
`endif

  // Row pattern for the current local column; segments and rows share polarity.
  always_comb begin
    rows = 8'hFF;
    unique case (col_idx[1:0])
      2'd0: begin
        rows[1] = seg[5];
        rows[2] = seg[5];
        rows[4] = seg[4];
        rows[5] = seg[4];
      end
      2'd3: begin
        rows[1] = seg[1];
        rows[2] = seg[1];
        rows[4] = seg[2];
        rows[5] = seg[2];
`ifdef SEVENSEG_DP_EN
        rows[7] = seg[7];
`endif
      end
      default: begin
        rows[0] = seg[0];
        rows[3] = seg[6];
        rows[6] = seg[3];
      end
    endcase
  end

  // Free-running prescaler; column advances on each prescaler wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc   <= '0;
      col_idx <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (wrap) begin
        if (col_idx == LAST) col_idx <= '0;
        else                 col_idx <= col_idx + 1'b1;
      end
    end
  end

  // Double buffer: pending swaps into display only at the frame boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp      <= '1;
      pend      <= '1;
      pend_full <= 1'b0;
    end else if (boundary && pend_full) begin
      disp      <= pend;
      pend_full <= 1'b0;
    end else if (accept) begin
      pend      <= load.seg_in;
      pend_full <= 1'b1;
    end
  end

  // Registered pin drive and frame marker, one cycle behind scan state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_out      <= 8'hFF;
      io_col      <= '1;
      frame_start <= 1'b0;
    end else begin
      io_out      <= lit ? rows : 8'hFF;
      io_col      <= lit ? col_n : '1;
      frame_start <= (presc == '0) && (col_idx == '0);
    end
  end
endmodule
